// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with private HI/LO registers.
// Start ops run for a fixed number of cycles with Busy high; the result is
// computed at issue, held in resHI/resLO and committed when the count expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          wr_q, wr_d;

  logic          is_start, is_div, is_signed_div;
  logic [63:0]   prod;
  logic [31:0]   a_mag, b_mag, div_a, div_b, div_b_safe;
  logic [31:0]   quo, rem;

  assign is_start      = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign is_div        = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign is_signed_div = (MDUOp == OP_DIV);

  // Arithmetic datapath: 64-bit product and magnitude-based divide
  always_comb begin
    if (MDUOp == OP_MULT)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'b0, A} * {32'b0, B};

    a_mag      = A[31] ? (32'd0 - A) : A;
    b_mag      = B[31] ? (32'd0 - B) : B;
    div_a      = is_signed_div ? a_mag : A;
    div_b      = is_signed_div ? b_mag : B;
    div_b_safe = (div_b == '0) ? 32'd1 : div_b;
    quo        = div_a / div_b_safe;
    rem        = div_a % div_b_safe;
    // Signed divide: quotient negated on sign mismatch, remainder takes dividend sign
    if (is_signed_div) begin
      if (A[31] ^ B[31]) quo = 32'd0 - quo;
      if (A[31])         rem = 32'd0 - rem;
    end
  end

  // Next-state logic for the IDLE/RUN sequencer and HI/LO
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (!Req) begin
          if (is_start) begin
            wr_d    = !(is_div && (B == '0));
            cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = S_RUN;
            if (is_div) begin
              res_hi_d = rem;
              res_lo_d = quo;
            end else begin
              res_hi_d = prod[63:32];
              res_lo_d = prod[31:0];
            end
          end else if (MDUOp == OP_MTHI) begin
            hi_d = A;
          end else if (MDUOp == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  // Output read port
  always_comb begin
    case (MDUOp)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: MDUOut = '0;
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus random traffic checked
// every cycle against a transaction-level HI/LO/busy model.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B), .Req(Req),
    .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          m_rem;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // {HI,LO} for a start op, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          q, r;
    longint unsigned uq, ur;
    logic [63:0]     res;
    res = '0;
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Advance one clock: update model from current inputs, then compare after the edge
  task automatic tick();
    logic [63:0] res;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; p_wr = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (!Req) begin
      if (MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
        p_wr = !(MDUOp >= 4'd3 && B == 32'h0);
        if (p_wr) begin
          res  = ref_result(MDUOp, A, B);
          p_hi = res[63:32];
          p_lo = res[31:0];
        end
        m_rem = (MDUOp <= 4'd2) ? MC : DC;
      end else if (MDUOp == 4'd7) begin
        m_hi = A;
      end else if (MDUOp == 4'd8) begin
        m_lo = A;
      end
    end
    @(posedge clk);
    #1;
    check("busy", {31'b0, Busy}, {31'b0, (m_rem > 0)});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("mduout", MDUOut, (MDUOp == 4'd5) ? m_hi : (MDUOp == 4'd6) ? m_lo : 32'h0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    MDUOp = op; A = a; B = b; Req = req;
    tick();
    MDUOp = 4'd0; Req = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, exp);
  endtask

  initial begin
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 0; m_rem = 0;
    reset = 1'b1; MDUOp = '0; A = '0; B = '0; Req = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_out", MDUOut, 32'h0);
    reset = 1'b0;
    tick();

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    busy_len("mult_busy_len", MC);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    busy_len("multu_busy_len", MC);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    busy_len("div_busy_len", DC);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    busy_len("divovf_busy_len", DC);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0);

    issue(4'd7, 32'h1234, 32'h0, 1'b0);
    issue(4'd8, 32'h5678, 32'h0, 1'b0);
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    busy_len("div0_busy_len", DC);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);
    MDUOp = 4'd5;
    #1;
    check("mfhi", MDUOut, 32'h1234);
    MDUOp = 4'd0;

    issue(4'd1, 32'd3, 32'd4, 1'b1);
    check("req_busy", {31'b0, Busy}, 32'h0);
    check("req_hi", HI, 32'h1234);
    check("req_lo", LO, 32'h5678);
    issue(4'd8, 32'hABCD, 32'h0, 1'b1);
    check("req_mtlo", LO, 32'h5678);
    tick();

    issue(4'd3, 32'd100, 32'd7, 1'b0);
    tick();
    tick();
    tick();
    check("rstmid_busy_pre", {31'b0, Busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", {31'b0, Busy}, 32'h0);
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    repeat (12) tick();
    check("rstmid_late_hi", HI, 32'h0);
    check("rstmid_late_lo", LO, 32'h0);

    for (int i = 0; i < 600; i++) begin
      MDUOp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      A     = rnd_word();
      B     = rnd_word();
      Req   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; MDUOp = '0; Req = 1'b0;
    repeat (DC + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
